pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the program counter and sequences its next value for the MIPS pipeline fetch stage.
- Redirect sources come from ID:
  - Sequential fetch: PC+4.
  - Jump: {pc4[31:28], target26, 2'b00}, the 26->28-bit word-shift path.
  - Taken branch: pc4 + (sext(imm16) << 2).
  - Register jump (jr).
- Handles fetch stalls by parking a redirect in a one-entry buffer until the stall releases.
- Drives the IF/ID flush.

Parameters:
- ADDR_W, 32, PC/address width; fixed at 32 for MIPS-I, kept as a parameter for the bench.
- TGT_W, 26, J-type target field width.
- IMM_W, 16, branch immediate width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- stall_i, input, 1, hazard unit holds the PC and IF/ID this cycle.
- redir_pc4_i, input, ADDR_W, PC+4 of the ID-stage instruction; base for jump and branch targets.
- jump_i, input, 1, ID holds J/JAL.
- jump_tgt_i, input, TGT_W, instr[25:0].
- jr_i, input, 1, ID holds JR/JALR.
- jr_addr_i, input, ADDR_W, forwarded rs value.
- br_taken_i, input, 1, ID branch resolved taken.
- br_imm_i, input, IMM_W, instr[15:0].
- pc_o, output, ADDR_W, current fetch PC (registered).
- pc_plus4_o, output, ADDR_W, pc_o + 4 (combinational).
- flush_o, output, 1, squash IF/ID at the coming edge (combinational).
- pending_o, output, 1, redirect parked in buffer (registered).
- align_err_o, output, 1, one-cycle pulse: accepted jr target with addr[1:0] != 0 (registered).

Behaviour:
- Reset state, at the edge with rst=1:
  - pc_o = RESET_PC; pending_o = 0; align_err_o = 0; the buffer's stored target is cleared to 0.
  - rst overrides everything, including mid-stall and a pending redirect.
  - flush_o = 0 whenever rst=1.
- Target formation, purely combinational, modulo 2^32 (carry discarded, no overflow flag):
  - jump: {redir_pc4_i[31:28], jump_tgt_i, 2'b00}.
  - branch: redir_pc4_i + {{14{imm[15]}}, imm, 2'b00}. Wrap-around is legal, e.g. 0xFFFF_FFFC + 8 -> 0x0000_0004.
  - jr: {jr_addr_i[31:2], 2'b00}. Alignment is forced; align_err_o pulses the cycle after acceptance.
- Redirect priority if several requests are asserted together: br_taken_i > jr_i > jump_i. A lower-priority request is dropped, not queued.
- FSM states:
  - RUN: no redirect parked.
  - HOLD: pending_o = 1, target stored in the buffer.
- RUN transitions:
  - No redirect, stall_i=0: pc <= pc+4.
  - No redirect, stall_i=1: pc holds.
  - Redirect, stall_i=0: pc <= target, flush_o = 1 this cycle, stay in RUN.
  - Redirect, stall_i=1: pc holds, buffer <= target, flush_o = 0, go to HOLD.
- HOLD transitions:
  - stall_i=1: pc and buffer hold. New redirect inputs are ignored; the first captured target wins.
  - stall_i=0: pc <= buffer, flush_o = 1, go to RUN. Redirect inputs in this cycle are ignored.
- flush_o is never asserted while stall_i=1.
- pc_plus4_o wraps: 0xFFFF_FFFC -> 0x0000_0000.
- Latency: target visible on pc_o one edge after acceptance. Minimum redirect penalty is 1 flushed slot.

Decomposition:
- Shared package mips_pkg:
  - ADDR_W, RESET_PC, TGT_W, IMM_W.
  - Redirect-source encoding: enum RD_NONE, RD_BR, RD_JR, RD_J.
  - FSM state enum ST_RUN, ST_HOLD.
- One sub-module, pc_target_gen: purely combinational; instantiates the existing 26->28 word-shift for jump and a 16->18 shift for the branch offset. It outputs the selected target, the redirect source and the misalignment flag. The FSM, PC register and buffer stay in pc_sequencer.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> pc_o = 0x0000_0000, pending_o = 0, flush_o = 0. After release, 3 free-run cycles -> pc_o = 0x4, 0x8, 0xC.
- Jump: redir_pc4_i = 0x4000_0010, jump_i = 1, jump_tgt_i = 0x3FF_FFFF, stall 0 -> flush_o = 1 that cycle; next pc_o = 0x4FFF_FFFC.
- Branch, negative offset and wrap:
  - pc4 = 0x0000_0100, imm = 0xFFFE -> pc_o = 0x0000_00F8.
  - pc4 = 0xFFFF_FFFC, imm = 0x0002 -> pc_o = 0x0000_0004.
- Stall park: br_taken_i = 1 (target 0x200) with stall_i = 1 for 3 cycles, and jump_i = 1 (different target) during the 2nd cycle:
  - pc_o held, pending_o = 1, flush_o = 0 throughout.
  - stall drops -> flush_o = 1, next pc_o = 0x200, pending_o = 0.
- Priority and jr alignment:
  - br_taken_i, jr_i and jump_i asserted together -> branch target taken.
  - jr_i alone with jr_addr_i = 0x0000_1003 -> pc_o = 0x0000_1000, align_err_o pulses for 1 cycle.
- Reset mid-HOLD: park a redirect, then assert rst while stall_i = 1 -> pc_o = RESET_PC, pending_o = 0. After release with stall 0, pc_o = 0x4 and the parked target is never applied.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS fetch-stage types and constants: address/field widths, redirect-source
// encoding, PC sequencer FSM states and the word-shift helpers used for target formation.
package mips_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned TGT_W    = 26;
    localparam int unsigned IMM_W    = 16;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_BR,
        RD_JR,
        RD_J
    } rd_src_e;

    typedef enum logic {
        ST_RUN,
        ST_HOLD
    } pc_state_e;

    // J-type target field to a 28-bit byte address.
    function automatic logic [TGT_W+1:0] word_shift26(input logic [TGT_W-1:0] tgt);
        return {tgt, 2'b00};
    endfunction

    // Branch immediate to an 18-bit byte offset, still unsigned here.
    function automatic logic [IMM_W+1:0] word_shift16(input logic [IMM_W-1:0] imm);
        return {imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_gen.sv
// Combinational redirect target former: picks the highest-priority redirect from ID
// (branch > jr > jump) and produces its target, source tag and jr misalignment flag.
module pc_target_gen #(
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
    parameter int unsigned TGT_W  = mips_pkg::TGT_W,
    parameter int unsigned IMM_W  = mips_pkg::IMM_W
) (
    input  logic [ADDR_W-1:0] redir_pc4_i,
    input  logic              jump_i,
    input  logic [TGT_W-1:0]  jump_tgt_i,
    input  logic              jr_i,
    input  logic [ADDR_W-1:0] jr_addr_i,
    input  logic              br_taken_i,
    input  logic [IMM_W-1:0]  br_imm_i,
    output logic [ADDR_W-1:0] tgt_o,
    output mips_pkg::rd_src_e src_o,
    output logic              misalign_o
);
    import mips_pkg::*;

    logic [TGT_W+1:0]  jump_off;
    logic [IMM_W+1:0]  br_off;
    logic [ADDR_W-1:0] jump_tgt;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] jr_tgt;

    assign jump_off = word_shift26(jump_tgt_i);
    assign br_off   = word_shift16(br_imm_i);

    // Jump keeps the upper region bits of pc4; the 28-bit offset fills the rest.
    assign jump_tgt = {redir_pc4_i[ADDR_W-1:TGT_W+2], jump_off};
    // Sign-extend the shifted offset; the add wraps modulo 2^ADDR_W.
    assign br_tgt   = redir_pc4_i + {{(ADDR_W-IMM_W-2){br_imm_i[IMM_W-1]}}, br_off};
    assign jr_tgt   = {jr_addr_i[ADDR_W-1:2], 2'b00};

    always_comb begin
        tgt_o      = '0;
        src_o      = RD_NONE;
        misalign_o = 1'b0;
        if (br_taken_i) begin
            tgt_o = br_tgt;
            src_o = RD_BR;
        end else if (jr_i) begin
            tgt_o      = jr_tgt;
            src_o      = RD_JR;
            misalign_o = |jr_addr_i[1:0];
        end else if (jump_i) begin
            tgt_o = jump_tgt;
            src_o = RD_J;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential PC+4, ID redirects, and a one-entry buffer that
// parks a redirect arriving during a stall until the stall releases.
module pc_sequencer #(
    parameter int unsigned      ADDR_W   = mips_pkg::ADDR_W,
    parameter int unsigned      TGT_W    = mips_pkg::TGT_W,
    parameter int unsigned      IMM_W    = mips_pkg::IMM_W,
    parameter logic [ADDR_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic [ADDR_W-1:0] redir_pc4_i,
    input  logic              jump_i,
    input  logic [TGT_W-1:0]  jump_tgt_i,
    input  logic              jr_i,
    input  logic [ADDR_W-1:0] jr_addr_i,
    input  logic              br_taken_i,
    input  logic [IMM_W-1:0]  br_imm_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              flush_o,
    output logic              pending_o,
    output logic              align_err_o
);
    import mips_pkg::*;

    pc_state_e         state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] buf_q;
    logic              align_err_q;

    logic [ADDR_W-1:0] redir_tgt;
    rd_src_e           redir_src;
    logic              redir_misalign;
    logic              redir_req;

    pc_target_gen #(
        .ADDR_W (ADDR_W),
        .TGT_W  (TGT_W),
        .IMM_W  (IMM_W)
    ) u_target_gen (
        .redir_pc4_i (redir_pc4_i),
        .jump_i      (jump_i),
        .jump_tgt_i  (jump_tgt_i),
        .jr_i        (jr_i),
        .jr_addr_i   (jr_addr_i),
        .br_taken_i  (br_taken_i),
        .br_imm_i    (br_imm_i),
        .tgt_o       (redir_tgt),
        .src_o       (redir_src),
        .misalign_o  (redir_misalign)
    );

    assign redir_req  = (redir_src != RD_NONE);
    assign pc_plus4_o = pc_q + ADDR_W'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            buf_q       <= '0;
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (redir_req) begin
                        align_err_q <= redir_misalign;
                        if (stall_i) begin
                            buf_q   <= redir_tgt;
                            state_q <= ST_HOLD;
                        end else begin
                            pc_q <= redir_tgt;
                        end
                    end else if (!stall_i) begin
                        pc_q <= pc_plus4_o;
                    end
                end
                // First parked target wins; redirects seen here are dropped.
                ST_HOLD: begin
                    if (!stall_i) begin
                        pc_q    <= buf_q;
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        flush_o = 1'b0;
        if (!rst && !stall_i) begin
            flush_o = (state_q == ST_HOLD) || redir_req;
        end
    end

    assign pc_o        = pc_q;
    assign pending_o   = (state_q == ST_HOLD);
    assign align_err_o = align_err_q;

endmodule
